msg_frame_asm: RTL and testbench

Framed, buffered successor to the raw UART message assembler: converts a stream of UART words into fixed-width messages only after detecting a start-of-frame word, then buffers complete messages in an internal FIFO for the controller. Adds resynchronisation, an inter-word timeout, drop-on-full overrun reporting and an optional checksum. Sits between `uart_rx` and `controller`, replacing the assembler + FIFO pair.

---
 rtl/msg_frame_asm.sv | 171 +++++++++++++++++
 tb/tb_msg_frame_asm.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_frame_asm.sv
// Framed UART message assembler with a show-ahead message FIFO.
// Optional XOR checksum word is enabled by defining MSG_FRAME_CHECKSUM_EN.
module msg_frame_asm #(
  parameter int WORD_SIZE = 8,
  parameter int WORDS_PER_PACKET = 4,
  parameter logic [WORD_SIZE-1:0] SOF_WORD = 8'hA5,
  parameter int TIMEOUT_CLKS = 1_125_000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic n_reset,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic data_in_valid,
  output logic [WORD_SIZE*WORDS_PER_PACKET-1:0] data_out,
  input  logic rd_en,
  output logic empty,
  output logic full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic frame_err,
  output logic overrun
);

  localparam int MW = WORD_SIZE * WORDS_PER_PACKET;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW =
    (WORDS_PER_PACKET > 1) ? $clog2(WORDS_PER_PACKET) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [IW-1:0] IDX_LAST = IW'(WORDS_PER_PACKET - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    PUSH
`ifdef MSG_FRAME_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

  state_t state, state_d;

  logic [IW-1:0] idx;
  logic [TW-1:0] tcnt;
  logic [MW-1:0] asm_q;
  logic [MW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_d;

  logic timeout, push, pop;
  logic fe_d, ov_d;

`ifdef MSG_FRAME_CHECKSUM_EN
  logic [WORD_SIZE-1:0] chk;
`endif

  assign timeout = !data_in_valid && (tcnt == T_LAST);
  assign push = (state == PUSH) && (!full || rd_en);
  assign pop = rd_en && !empty;
  assign ov_d = (state == PUSH) && full && !rd_en;
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= HUNT;
    else state <= state_d;
  end

  always_comb begin
    state_d = state;
    fe_d = 1'b0;
    unique case (state)
      HUNT: begin
        if (data_in_valid && data_in == SOF_WORD)
          state_d = PAYLOAD;
      end
      PAYLOAD: begin
        if (data_in_valid) begin
          if (idx == IDX_LAST) begin
`ifdef MSG_FRAME_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = PUSH;
`endif
          end
        end else if (timeout) begin
          fe_d = 1'b1;
          state_d = HUNT;
        end
      end
`ifdef MSG_FRAME_CHECKSUM_EN
      CHECK: begin
        if (data_in_valid) begin
          if (data_in == chk) begin
            state_d = PUSH;
          end else begin
            fe_d = 1'b1;
            state_d = HUNT;
          end
        end else if (timeout) begin
          fe_d = 1'b1;
          state_d = HUNT;
        end
      end
`endif
      PUSH: state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    count_d = count;
    if (push && !pop) count_d = count + CW'(1);
    else if (!push && pop) count_d = count - CW'(1);
  end

  // Assembly side: word slot, idle timer and running checksum.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      idx <= '0;
      tcnt <= '0;
      asm_q <= '0;
`ifdef MSG_FRAME_CHECKSUM_EN
      chk <= '0;
`endif
    end else begin
      if (data_in_valid || state == HUNT || state == PUSH)
        tcnt <= '0;
      else
        tcnt <= tcnt + TW'(1);
      if (state == HUNT) begin
        idx <= '0;
`ifdef MSG_FRAME_CHECKSUM_EN
        chk <= '0;
`endif
      end else if (state == PAYLOAD && data_in_valid) begin
        asm_q[MW-WORD_SIZE*(int'(idx)+1) +: WORD_SIZE] <= data_in;
        idx <= idx + IW'(1);
`ifdef MSG_FRAME_CHECKSUM_EN
        chk <= chk ^ data_in;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= asm_q;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count_d;
      empty <= (count_d == '0);
      full <= (count_d == DEPTH);
      frame_err <= fe_d;
      overrun <= ov_d;
    end
  end

endmodule

// File: tb/tb_msg_frame_asm.sv
// Randomized bench for msg_frame_asm against a queue-based message model.
// Works with or without MSG_FRAME_CHECKSUM_EN defined.
module tb_msg_frame_asm;

  localparam int W = 8;
  localparam int N = 4;
  localparam int MW = W * N;
  localparam int DEPTH = 8;
  localparam int TO = 40;
  localparam logic [7:0] SOF = 8'hA5;
`ifdef MSG_FRAME_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic [W-1:0] data_in = '0;
  logic data_in_valid = 1'b0;
  logic [MW-1:0] data_out;
  logic rd_en = 1'b0;
  logic empty, full;
  logic [$clog2(DEPTH):0] count;
  logic frame_err, overrun;

  int n_checks = 0;
  int n_fail = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [MW-1:0] q[$];

  msg_frame_asm #(
    .WORD_SIZE(W),
    .WORDS_PER_PACKET(N),
    .SOF_WORD(SOF),
    .TIMEOUT_CLKS(TO),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .data_out(data_out),
    .rd_en(rd_en),
    .empty(empty),
    .full(full),
    .count(count),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w);
    data_in = w;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [7:0] word_of(input logic [MW-1:0] m,
                                         input int i);
    return m[MW-W*(i+1) +: W];
  endfunction

  function automatic logic [7:0] xsum(input logic [MW-1:0] m);
    logic [7:0] x = '0;
    for (int i = 0; i < N; i++) x ^= word_of(m, i);
    return x;
  endfunction

  // Returns on the falling edge after the push cycle.
  task automatic send_frame(input logic [MW-1:0] m,
                            input logic [7:0] bad,
                            input bit rd);
    logic [7:0] last;
    send_word(SOF);
    for (int i = 0; i < N - 1; i++) send_word(word_of(m, i));
    if (CK) begin
      send_word(word_of(m, N - 1));
      last = xsum(m) ^ bad;
    end else begin
      last = word_of(m, N - 1);
    end
    data_in = last;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    rd_en = rd;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic run_frame(input logic [MW-1:0] m,
                           input logic [7:0] bad,
                           input bit rd);
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    bit bad_frame = CK && (bad != 0);
    bit exp_ov = 1'b0;
    send_frame(m, bad, rd);
    if (!bad_frame) begin
      if (rd && q.size() > 0) void'(q.pop_front());
      if (q.size() < DEPTH) q.push_back(m);
      else exp_ov = 1'b1;
    end
    idle(1);
    check("frame_err_pulses", 64'(fe_cnt - fe0), 64'(bad_frame));
    check("overrun_pulses", 64'(ov_cnt - ov0), 64'(exp_ov));
    check("count", 64'(count), 64'(q.size()));
    check("full", 64'(full), 64'(q.size() == DEPTH));
    check("empty", 64'(empty), 64'(q.size() == 0));
  endtask

  task automatic pop_one();
    check("head", 64'(data_out), 64'(q[0]));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    void'(q.pop_front());
    check("count_after_pop", 64'(count), 64'(q.size()));
  endtask

  task automatic drain();
    while (q.size() > 0) pop_one();
    check("drained_empty", 64'(empty), 64'd1);
  endtask

  task automatic abort_timeout(input int k);
    int fe0 = fe_cnt;
    send_word(SOF);
    for (int i = 0; i < k; i++) send_word(8'($urandom));
    idle(TO + 2);
    check("timeout_pulse", 64'(fe_cnt - fe0), 64'd1);
    check("timeout_count", 64'(count), 64'(q.size()));
  endtask

  initial begin
    logic [MW-1:0] m;
    int fe0, ov0;
    idle(2);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_fe", 64'(frame_err), 64'd0);
    check("rst_ov", 64'(overrun), 64'd0);
    n_reset = 1'b1;
    idle(2);

    rd_en = 1'b1;
    idle(3);
    rd_en = 1'b0;
    check("rd_empty_count", 64'(count), 64'd0);
    check("rd_empty_empty", 64'(empty), 64'd1);
    check("rd_empty_full", 64'(full), 64'd0);

    // Push latency: empty falls only after the cycle following the last word.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_word(SOF);
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    if (CK) send_word(8'h44);
    data_in = 8'h44;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    check("lat_empty_E", 64'(empty), 64'd1);
    @(negedge clk);
    check("lat_empty_E1", 64'(empty), 64'd0);
    check("lat_data", 64'(data_out), 64'h11223344);
    check("lat_count", 64'(count), 64'd1);
    q.push_back(32'h11223344);
    idle(1);
    check("lat_fe", 64'(fe_cnt - fe0), 64'd0);
    check("lat_ov", 64'(ov_cnt - ov0), 64'd0);
    drain();

    if (CK) begin
      send_word(8'h00);
      send_word(8'h7F);
      run_frame(32'h01020304, 8'h00, 1'b0);
      check("ck_good_data", 64'(data_out), 64'h01020304);
      run_frame(32'h01020304, 8'h01, 1'b0);
      drain();
    end

    // Exact timeout edge.
    send_word(SOF);
    send_word(8'h01);
    data_in = 8'h02;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    idle(TO - 1);
    check("to_before", 64'(frame_err), 64'd0);
    @(negedge clk);
    check("to_fire", 64'(frame_err), 64'd1);
    @(negedge clk);
    check("to_after", 64'(frame_err), 64'd0);
    run_frame(32'hDEADBEEF, 8'h00, 1'b0);
    check("to_recover", 64'(data_out), 64'hDEADBEEF);
    drain();

    for (int i = 0; i < DEPTH; i++) run_frame(MW'($urandom), 8'h00, 1'b0);
    run_frame(MW'($urandom), 8'h00, 1'b0);
    run_frame(MW'($urandom), 8'h00, 1'b1);
    drain();

    for (int i = 0; i < 3; i++) run_frame(MW'($urandom), 8'h00, 1'b0);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_word(SOF);
    send_word(8'h01);
    n_reset = 1'b0;
    #1;
    check("mid_rst_empty", 64'(empty), 64'd1);
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_full", 64'(full), 64'd0);
    check("mid_rst_data", 64'(data_out), 64'd0);
    @(negedge clk);
    n_reset = 1'b1;
    q.delete();
    idle(2);
    check("mid_rst_fe", 64'(fe_cnt - fe0), 64'd0);
    check("mid_rst_ov", 64'(ov_cnt - ov0), 64'd0);
    run_frame(32'hCAFE5A5A, 8'h00, 1'b0);
    drain();

    for (int it = 0; it < 60; it++) begin
      int kind = $urandom_range(0, 7);
      int junk = $urandom_range(0, 3);
      for (int j = 0; j < junk; j++) begin
        logic [7:0] w = 8'($urandom);
        if (w == SOF) w = 8'h5A;
        send_word(w);
      end
      m = '0;
      for (int j = 0; j < N; j++) begin
        logic [7:0] w = 8'($urandom);
        if ($urandom_range(0, 3) == 0) w = SOF;
        m[MW-W*(j+1) +: W] = w;
      end
      if (kind == 0) abort_timeout($urandom_range(0, N - 1));
      else if (kind == 1 && CK)
        run_frame(m, 8'($urandom_range(1, 255)), 1'b0);
      else run_frame(m, 8'h00, kind == 2);
      if (q.size() > 0 && $urandom_range(0, 2) == 0) pop_one();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
